// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one byte/word RAM between an instruction-fetch port and a load/store port, fixed 3-cycle latency.
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed priority to port 0.
module ram_arbiter #(
    parameter int MEM_BYTES = 32,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic [ADDR_W-1:0] p0_addr,
    output logic              p0_gnt,
    output logic              p0_rsp_valid,
    output logic [31:0]       p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic              p1_word,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [31:0]       p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rsp_valid,
    output logic [31:0]       p1_rdata,
    output logic              p1_err,
    output logic              ram_write_enable,
    output logic              ram_is32bitWrite,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_bus_to_mem,
    output logic [31:0]       ram_bus_to_mem_32,
    input  logic [7:0]        ram_bus_from_mem,
    input  logic [31:0]       ram_bus_from_mem_32
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [ADDR_W:0] LIM  = (ADDR_W+1)'(MEM_BYTES);
    localparam logic [ADDR_W:0] FOUR = (ADDR_W+1)'(4);

    state_t            state, state_nxt;
    logic              sel, grant, nxt_word, nxt_err;
    logic [ADDR_W-1:0] nxt_addr;
    logic              cmd_port, cmd_we, cmd_word, cmd_err;
    logic [ADDR_W-1:0] cmd_addr;
    logic [31:0]       cmd_wdata, rdata_q;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic last;
    // last == 1 means port 1 was granted most recently, so port 0 wins the next tie
    assign sel = p1_req & (~p0_req | ~last);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last <= 1'b1;
        else if (grant)
            last <= sel;
    end
`else
    assign sel = p1_req & ~p0_req;
`endif

    assign grant    = rst_n & (state == IDLE) & (p0_req | p1_req);
    assign nxt_word = ~sel | p1_word;
    assign nxt_addr = sel ? p1_addr : p0_addr;
    // one extra bit of width keeps addr+4 from wrapping near the top of the address space
    assign nxt_err  = nxt_word ? ({1'b0, nxt_addr} + FOUR > LIM) : ({1'b0, nxt_addr} >= LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = (state == IDLE)   ? ((p0_req | p1_req) ? ACCESS : IDLE) :
                    (state == ACCESS) ? RESP : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_port  <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_word  <= 1'b0;
            cmd_err   <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            if (grant) begin
                cmd_port  <= sel;
                cmd_we    <= sel & p1_we;
                cmd_word  <= nxt_word;
                cmd_err   <= nxt_err;
                cmd_addr  <= nxt_addr;
                cmd_wdata <= sel ? p1_wdata : 32'h0;
            end
            if (state == ACCESS)
                rdata_q <= (cmd_err | cmd_we) ? 32'h0 :
                           cmd_word ? ram_bus_from_mem_32 : {24'h0, ram_bus_from_mem};
        end
    end

    always_comb begin
        p0_gnt            = grant & ~sel;
        p1_gnt            = grant & sel;
        ram_write_enable  = (state == ACCESS) & cmd_we & ~cmd_err;
        ram_is32bitWrite  = (state == ACCESS) & cmd_word;
        ram_addr          = cmd_addr;
        ram_bus_to_mem    = cmd_wdata[7:0];
        ram_bus_to_mem_32 = cmd_wdata;
        p0_rsp_valid      = (state == RESP) & ~cmd_port;
        p1_rsp_valid      = (state == RESP) & cmd_port;
        p0_rdata          = p0_rsp_valid ? rdata_q : 32'h0;
        p1_rdata          = p1_rsp_valid ? rdata_q : 32'h0;
        p0_err            = p0_rsp_valid & cmd_err;
        p1_err            = p1_rsp_valid & cmd_err;
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: random and directed traffic against a transaction-level model of the arbiter and its RAM.
module tb_ram_arbiter;
    localparam int MB = 32;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        p0_req = 1'b0, p1_req = 1'b0, p1_we = 1'b0, p1_word = 1'b0;
    logic [31:0] p0_addr = '0, p1_addr = '0, p1_wdata = '0;
    logic        p0_gnt, p0_rsp_valid, p0_err, p1_gnt, p1_rsp_valid, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        ram_write_enable, ram_is32bitWrite;
    logic [31:0] ram_addr, ram_bus_to_mem_32, ram_bus_from_mem_32;
    logic [7:0]  ram_bus_to_mem, ram_bus_from_mem;

    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.MEM_BYTES(MB), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_gnt(p0_gnt), .p0_rsp_valid(p0_rsp_valid),
        .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_word(p1_word), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rsp_valid(p1_rsp_valid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .ram_write_enable(ram_write_enable), .ram_is32bitWrite(ram_is32bitWrite), .ram_addr(ram_addr),
        .ram_bus_to_mem(ram_bus_to_mem), .ram_bus_to_mem_32(ram_bus_to_mem_32),
        .ram_bus_from_mem(ram_bus_from_mem), .ram_bus_from_mem_32(ram_bus_from_mem_32)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // RAM: combinational reads, byte/word writes on the clock edge
    logic [7:0] ram [0:MB-1];
    logic       init_done = 1'b0;
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < MB; i++) ram[i] <= 8'(i * 37 + 5);
            init_done <= 1'b1;
        end else if (ram_write_enable) begin
            if (ram_is32bitWrite) begin
                for (int i = 0; i < 4; i++)
                    if (ram_addr + 32'(i) < 32'(MB)) ram[5'(ram_addr + 32'(i))] <= ram_bus_to_mem_32[8*i +: 8];
            end else if (ram_addr < 32'(MB)) begin
                ram[5'(ram_addr)] <= ram_bus_to_mem;
            end
        end
    end
    assign ram_bus_from_mem = (ram_addr < 32'(MB)) ? ram[5'(ram_addr)] : 8'h0;
    for (genvar g = 0; g < 4; g++) begin : g_rd
        assign ram_bus_from_mem_32[8*g +: 8] = (ram_addr + 32'(g) < 32'(MB)) ? ram[5'(ram_addr + 32'(g))] : 8'h0;
    end

    // transaction-level model: a grant at cycle c owns the RAM for c+1 and answers at c+2
    logic [7:0]  mem_ref [0:MB-1];
    bit          minit = 0, t_v = 0, t_port, t_we, t_word, t_err, last = 1;
    logic [31:0] t_addr, t_wdata, t_rdata;
    int          cyc = 0, t_gc = 0, next_free = 0;
    bit          g, s, acc, rsp;
    longint      la;

    always @(negedge clk) begin
        cyc++;
        if (!minit) begin
            for (int i = 0; i < MB; i++) mem_ref[i] = 8'(i * 37 + 5);
            minit = 1;
        end
        if (!rst_n) begin
            chk("reset_outs", {p0_gnt, p1_gnt, p0_rsp_valid, p1_rsp_valid, p0_err, p1_err,
                               ram_write_enable, ram_is32bitWrite}, 0);
            chk("reset_rdata", {p0_rdata, p1_rdata}, 0);
            t_v = 0;
            next_free = 0;
            last = 1;
        end else begin
            g = (p0_req || p1_req) && cyc >= next_free;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            s = p1_req && (!p0_req || last == 0);
`else
            s = !p0_req;
`endif
            acc = t_v && cyc == t_gc + 1;
            rsp = t_v && cyc == t_gc + 2;
            if (acc) begin
                la = longint'(t_addr);
                t_rdata = 32'h0;
                if (!t_err && !t_we)
                    t_rdata = t_word ? {mem_ref[la+3], mem_ref[la+2], mem_ref[la+1], mem_ref[la]}
                                     : {24'h0, mem_ref[la]};
                if (!t_err && t_we) begin
                    if (t_word) for (int i = 0; i < 4; i++) mem_ref[la+i] = t_wdata[8*i +: 8];
                    else mem_ref[la] = t_wdata[7:0];
                end
                chk("ram_addr", ram_addr, t_addr);
                if (t_we && !t_err) chk("ram_wdata", t_word ? ram_bus_to_mem_32 : {24'h0, ram_bus_to_mem},
                                        t_word ? t_wdata : {24'h0, t_wdata[7:0]});
            end
            chk("gnt", {p0_gnt, p1_gnt}, {g && !s, g && s});
            chk("ram_we", ram_write_enable, acc && t_we && !t_err);
            chk("ram_is32", ram_is32bitWrite, acc && t_word);
            chk("rsp_valid", {p0_rsp_valid, p1_rsp_valid}, {rsp && !t_port, rsp && t_port});
            chk("p0_rdata", p0_rdata, (rsp && !t_port) ? t_rdata : 32'h0);
            chk("p1_rdata", p1_rdata, (rsp && t_port) ? t_rdata : 32'h0);
            chk("err", {p0_err, p1_err}, {rsp && !t_port && t_err, rsp && t_port && t_err});
            if (g) begin
                t_v = 1; t_gc = cyc; t_port = s; last = s;
                t_we = s && p1_we;
                t_word = !s || p1_word;
                t_addr = s ? p1_addr : p0_addr;
                t_wdata = p1_wdata;
                la = longint'(t_addr);
                t_err = t_word ? (la + 4 > MB) : (la >= MB);
                next_free = cyc + 3;
            end
        end
    end

    task automatic p1_do(input bit we, input bit word, input logic [31:0] a, input logic [31:0] d);
        bit ok = 0;
        @(posedge clk); #1;
        p1_req = 1; p1_we = we; p1_word = word; p1_addr = a; p1_wdata = d;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = p1_gnt;
        end
        if (!ok) chk("p1_gnt_timeout", 0, 1);
        @(posedge clk); #1;
        p1_req = 0;
    endtask

    task automatic p0_do(input logic [31:0] a);
        bit ok = 0;
        @(posedge clk); #1;
        p0_req = 1; p0_addr = a;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = p0_gnt;
        end
        if (!ok) chk("p0_gnt_timeout", 0, 1);
        @(posedge clk); #1;
        p0_req = 0;
    endtask

    task automatic wait_rsp(input bit port, output logic [31:0] rd, output bit er, output bit we_seen);
        bit ok = 0;
        we_seen = 0; rd = 'x; er = 1'bx;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            we_seen |= ram_write_enable;
            ok = port ? p1_rsp_valid : p0_rsp_valid;
            rd = port ? p1_rdata : p0_rdata;
            er = port ? p1_err : p0_err;
        end
        if (!ok) chk("rsp_timeout", 0, 1);
    endtask

    function automatic logic [31:0] rand_addr();
        return ($urandom_range(0, 3) == 0) ? 32'($urandom_range(24, 40)) : 32'($urandom_range(0, 31));
    endfunction

    task automatic drive0(input int n);
        bit seen;
        for (int i = 0; i < n; i++) begin
            @(negedge clk); seen = p0_gnt;
            @(posedge clk); #1;
            if (seen) p0_req = 0;
            if (!p0_req && $urandom_range(0, 2) == 0) begin
                p0_req = 1; p0_addr = rand_addr();
            end
        end
        @(posedge clk); #1; p0_req = 0;
    endtask

    task automatic drive1(input int n);
        bit seen;
        for (int i = 0; i < n; i++) begin
            @(negedge clk); seen = p1_gnt;
            @(posedge clk); #1;
            if (seen) p1_req = 0;
            if (!p1_req && $urandom_range(0, 1) == 0) begin
                p1_req = 1; p1_addr = rand_addr(); p1_we = 1'($urandom); p1_word = 1'($urandom);
                p1_wdata = $urandom;
            end
        end
        @(posedge clk); #1; p1_req = 0;
    endtask

    logic [31:0] rd;
    bit          er, wes;
    int          gk [4];
    bit          gp [4];
    int          ng;
    logic [7:0]  keep;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("post_reset_idle", {p0_gnt, p1_gnt, p0_rsp_valid, p1_rsp_valid, ram_write_enable, ram_addr}, 0);

        // arbitration under continuous requests from both ports
        @(posedge clk); #1;
        p0_req = 1; p0_addr = 32'h10; p1_req = 1; p1_we = 0; p1_word = 1; p1_addr = 32'h0;
        ng = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if ((p0_gnt || p1_gnt) && ng < 4) begin gk[ng] = k; gp[ng] = p1_gnt; ng++; end
        end
        @(posedge clk); #1; p0_req = 0; p1_req = 0;
        chk("arb_count", ng, 4);
        chk("arb_cycles", {gk[0][7:0], gk[1][7:0], gk[2][7:0], gk[3][7:0]}, 32'h00030609);
`ifdef RAM_ARB_ROUND_ROBIN_EN
        chk("arb_ports", {gp[0], gp[1], gp[2], gp[3]}, 4'b0101);
`else
        chk("arb_ports", {gp[0], gp[1], gp[2], gp[3]}, 4'b0000);
`endif
        repeat (2) @(posedge clk);

        // data path and write timing
        p1_do(1, 1, 32'h08, 32'hAABBCCDD);
        chk("t_gnt_drop", p1_gnt, 0);
        @(negedge clk);
        chk("t_we_T1", {ram_write_enable, ram_is32bitWrite, p1_rsp_valid}, 3'b110);
        @(negedge clk);
        chk("t_rsp_T2", {ram_write_enable, p1_rsp_valid, p0_rsp_valid, p1_err}, 4'b0100);
        @(negedge clk);
        chk("t_idle_T3", {ram_write_enable, p1_rsp_valid}, 0);
        p1_do(0, 0, 32'h09, 32'h0);
        wait_rsp(1, rd, er, wes);
        chk("byte_read_09", {er, rd}, {1'b0, 32'h000000CC});
        p0_do(32'h08);
        wait_rsp(0, rd, er, wes);
        chk("p0_read_08", {er, rd}, {1'b0, 32'hAABBCCDD});

        // range checks
        p1_do(1, 1, 32'h1D, 32'h12345678);
        wait_rsp(1, rd, er, wes);
        chk("range_ww_1D", {er, wes}, 2'b10);
        p1_do(0, 1, 32'h1C, 32'h0);
        wait_rsp(1, rd, er, wes);
        chk("range_wr_1C", er, 0);
        p1_do(1, 0, 32'h1F, 32'h000000E7);
        wait_rsp(1, rd, er, wes);
        chk("range_bw_1F", {er, wes}, 2'b01);
        p1_do(0, 0, 32'h20, 32'h0);
        wait_rsp(1, rd, er, wes);
        chk("range_br_20", {er, rd}, {1'b1, 32'h0});
        p0_do(32'hFFFF_FFFE);
        wait_rsp(0, rd, er, wes);
        chk("range_p0_nowrap", {er, rd}, {1'b1, 32'h0});

        // reset in the middle of a write
        keep = ram[4];
        p1_do(1, 1, 32'h04, 32'h5A5A5A5A);
        #1 chk("mid_access_we", ram_write_enable, 1);
        rst_n = 0;
        #1 chk("async_we_drop", ram_write_enable, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_rsp_in_reset", {p0_rsp_valid, p1_rsp_valid}, 0);
        end
        chk("aborted_write", ram[4], keep);
        @(posedge clk); #1 rst_n = 1;
        p0_req = 1; p0_addr = 32'h0; p1_req = 1; p1_we = 0; p1_word = 1; p1_addr = 32'h4;
        @(negedge clk);
        chk("first_tie_p0", {p0_gnt, p1_gnt}, 2'b10);
        @(posedge clk); #1 p0_req = 0;
        for (int i = 0; i < 10 && p1_req; i++) begin
            @(negedge clk);
            if (p1_gnt) begin @(posedge clk); #1 p1_req = 0; end
        end
        p1_req = 0;
        repeat (3) @(posedge clk);

        // randomized traffic
        fork
            drive0(400);
            drive1(400);
        join
        repeat (5) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < MB; i++) chk("ram_contents", ram[i], mem_ref[i]);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=done");
        $fatal(1);
    end
endmodule
